// File: rtl/param_commit_ctrl_if.sv
// rtl/param_commit_ctrl_if.sv - byte/packet/frame bundle between receiver, tb and param_commit_ctrl
interface param_commit_ctrl_if #(parameter int NBYTES = 60);
  logic                  byte_valid;
  logic [6:0]            byte_idx;
  logic [7:0]            byte_data;
  logic                  pkt_done;
  logic                  frame_start;
  logic                  vs_busy;
  logic [8*NBYTES-1:0]   params_out;
  logic                  commit_pulse;
  logic                  err_incomplete;
  logic                  overrun;
  logic [7:0]            commit_count;
  logic [2:0]            state_out;

  modport master (
    output byte_valid, byte_idx, byte_data, pkt_done, frame_start, vs_busy,
    input  params_out, commit_pulse, err_incomplete, overrun, commit_count, state_out
  );

  modport slave (
    input  byte_valid, byte_idx, byte_data, pkt_done, frame_start, vs_busy,
    output params_out, commit_pulse, err_incomplete, overrun, commit_count, state_out
  );
endinterface

// File: rtl/param_commit_ctrl.sv
// rtl/param_commit_ctrl.sv - double-buffered scene parameter bank, committed on a frame boundary
module param_commit_ctrl #(
  parameter int NBYTES      = 60,
  parameter int TIMEOUT_CYC = 20000
) (
  input logic                 clk_40,
  input logic                 reset,
  param_commit_ctrl_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ARMED  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t              state;
  logic [8*NBYTES-1:0] shadow;
  logic [8*NBYTES-1:0] active;
  logic [NBYTES-1:0]   mask;
  logic [NBYTES-1:0]   idx_hit;
  logic [NBYTES-1:0]   mask_next;
  logic [CW-1:0]       idle_cnt;
  logic                idx_ok;
  logic                commit_pulse_q;
  logic                err_q;
  logic                overrun_q;
  logic [7:0]          commit_count_q;

  // One-hot decode of byte_idx; an all-zero result means the index is out of range.
  always_comb begin
    idx_hit = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (bus.byte_idx == 7'(k)) idx_hit[k] = 1'b1;
    end
  end

  assign idx_ok    = |idx_hit;
  // Byte arriving alongside pkt_done still counts toward completeness.
  assign mask_next = mask | (idx_hit & {NBYTES{bus.byte_valid}});

  always_ff @(posedge clk_40) begin
    if (reset) begin
      state          <= IDLE;
      shadow         <= '0;
      active         <= '0;
      mask           <= '0;
      idle_cnt       <= '0;
      commit_pulse_q <= 1'b0;
      err_q          <= 1'b0;
      overrun_q      <= 1'b0;
      commit_count_q <= 8'd0;
    end else begin
      commit_pulse_q <= 1'b0;
      err_q          <= 1'b0;
      overrun_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.byte_valid && bus.byte_idx == 7'd0) begin
            shadow[7:0] <= bus.byte_data;
            mask        <= {{(NBYTES-1){1'b0}}, 1'b1};
            idle_cnt    <= '0;
            state       <= LOAD;
          end
        end
        LOAD: begin
          if (bus.byte_valid && !idx_ok) begin
            err_q <= 1'b1;
            state <= IDLE;
          end else begin
            if (bus.byte_valid) begin
              for (int k = 0; k < NBYTES; k++) begin
                if (idx_hit[k]) shadow[8*k +: 8] <= bus.byte_data;
              end
              mask     <= mask_next;
              idle_cnt <= '0;
            end
            if (bus.pkt_done) begin
              if (&mask_next) begin
                state <= ARMED;
              end else begin
                err_q <= 1'b1;
                state <= IDLE;
              end
            end else if (!bus.byte_valid) begin
              if (idle_cnt == CW'(TIMEOUT_CYC - 1)) begin
                err_q <= 1'b1;
                state <= IDLE;
              end else begin
                idle_cnt <= idle_cnt + 1'b1;
              end
            end
          end
        end
        ARMED: begin
          if (bus.byte_valid) overrun_q <= 1'b1;
          if (bus.frame_start && !bus.vs_busy) state <= COMMIT;
        end
        COMMIT: begin
          if (bus.byte_valid) overrun_q <= 1'b1;
          active         <= shadow;
          commit_count_q <= commit_count_q + 8'd1;
          commit_pulse_q <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.params_out     = active;
  assign bus.commit_pulse   = commit_pulse_q;
  assign bus.err_incomplete = err_q;
  assign bus.overrun        = overrun_q;
  assign bus.commit_count   = commit_count_q;
  assign bus.state_out      = {1'b0, state};

endmodule

// File: tb/tb_param_commit_ctrl.sv
// tb/tb_param_commit_ctrl.sv - directed self-checking bench for param_commit_ctrl
`timescale 1ns/1ps
module tb_param_commit_ctrl;
  localparam int NB = 60;
  localparam int TO = 20000;
  localparam int W  = 8*NB;

  logic clk_40 = 1'b0;
  logic reset  = 1'b1;
  always #12.5 clk_40 = ~clk_40;

  param_commit_ctrl_if #(.NBYTES(NB)) bus();

  param_commit_ctrl #(.NBYTES(NB), .TIMEOUT_CYC(TO)) dut (
    .clk_40 (clk_40),
    .reset  (reset),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_bank;
  logic [7:0]   exp_count;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [7:0] pat(input int kind, input int k);
    case (kind)
      0:       return 8'(k + 1);
      1:       return 8'(k*3 + 7);
      2:       return 8'(255 - k);
      default: return 8'(k ^ 'h3C);
    endcase
  endfunction

  function automatic logic [W-1:0] bank(input int kind);
    logic [W-1:0] b;
    for (int k = 0; k < NB; k++) b[8*k +: 8] = pat(kind, k);
    return b;
  endfunction

  task automatic step();
    @(negedge clk_40);
  endtask

  task automatic drive_byte(input int idx, input logic [7:0] d, input logic done, input logic fs);
    bus.byte_valid  = 1'b1;
    bus.byte_idx    = 7'(idx);
    bus.byte_data   = d;
    bus.pkt_done    = done;
    bus.frame_start = fs;
    step();
    bus.byte_valid  = 1'b0;
    bus.pkt_done    = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic strobe(input logic done, input logic fs, input logic busy);
    bus.pkt_done    = done;
    bus.frame_start = fs;
    bus.vs_busy     = busy;
    step();
    bus.pkt_done    = 1'b0;
    bus.frame_start = 1'b0;
    bus.vs_busy     = 1'b0;
  endtask

  task automatic send_bytes(input int kind, input int first, input int last);
    for (int k = first; k <= last; k++) drive_byte(k, pat(kind, k), 1'b0, 1'b0);
  endtask

  task automatic commit_and_check(input int kind);
    strobe(1'b0, 1'b1, 1'b0);
    check_eq("commit_state", bus.state_out, 3);
    check_eq("pulse_early", bus.commit_pulse, 0);
    step();
    exp_bank  = bank(kind);
    exp_count = exp_count + 8'd1;
    check_eq("commit_pulse", bus.commit_pulse, 1);
    check_eq("params_after_commit", bus.params_out, exp_bank);
    check_eq("commit_count", bus.commit_count, exp_count);
    check_eq("idle_after_commit", bus.state_out, 0);
    step();
    check_eq("pulse_single", bus.commit_pulse, 0);
  endtask

  initial begin
    bus.byte_valid  = 1'b0;
    bus.byte_idx    = 7'd0;
    bus.byte_data   = 8'd0;
    bus.pkt_done    = 1'b0;
    bus.frame_start = 1'b0;
    bus.vs_busy     = 1'b0;
    exp_bank  = '0;
    exp_count = 8'd0;

    step(); step();
    reset = 1'b0;
    check_eq("rst_state", bus.state_out, 0);
    check_eq("rst_params", bus.params_out, 0);
    check_eq("rst_count", bus.commit_count, 0);
    check_eq("rst_flags", {bus.commit_pulse, bus.err_incomplete, bus.overrun}, 0);

    // Nonzero index in IDLE is silently ignored
    drive_byte(5, 8'h12, 1'b0, 1'b0);
    check_eq("idle_ignore_state", bus.state_out, 0);
    check_eq("idle_ignore_err", bus.err_incomplete, 0);

    // Incomplete packet: bytes 0..58 then pkt_done
    send_bytes(0, 0, NB-2);
    check_eq("load_state", bus.state_out, 1);
    strobe(1'b1, 1'b0, 1'b0);
    check_eq("incomplete_err", bus.err_incomplete, 1);
    check_eq("incomplete_state", bus.state_out, 0);
    step();
    check_eq("incomplete_err_single", bus.err_incomplete, 0);
    strobe(1'b0, 1'b1, 1'b0);
    step();
    check_eq("incomplete_no_pulse", bus.commit_pulse, 0);
    check_eq("incomplete_params", bus.params_out, 0);

    // Full packet, then commit
    send_bytes(0, 0, NB-1);
    strobe(1'b1, 1'b0, 1'b0);
    check_eq("armed_state", bus.state_out, 2);
    check_eq("armed_no_err", bus.err_incomplete, 0);
    check_eq("armed_params_old", bus.params_out, 0);
    commit_and_check(0);

    // Last byte + pkt_done + frame_start together; busy gate
    send_bytes(1, 0, NB-2);
    drive_byte(NB-1, pat(1, NB-1), 1'b1, 1'b1);
    check_eq("same_cycle_armed", bus.state_out, 2);
    strobe(1'b1, 1'b0, 1'b0);
    check_eq("armed_pktdone_ignored", bus.state_out, 2);
    check_eq("armed_pktdone_no_err", bus.err_incomplete, 0);
    strobe(1'b0, 1'b1, 1'b1);
    check_eq("busy_stays_armed", bus.state_out, 2);
    step();
    check_eq("busy_no_pulse", bus.commit_pulse, 0);
    check_eq("busy_params_old", bus.params_out, exp_bank);
    commit_and_check(1);

    // Overrun while armed
    send_bytes(2, 0, NB-1);
    strobe(1'b1, 1'b0, 1'b0);
    drive_byte(0, 8'hAA, 1'b0, 1'b0);
    check_eq("overrun_pulse", bus.overrun, 1);
    check_eq("overrun_state", bus.state_out, 2);
    step();
    check_eq("overrun_single", bus.overrun, 0);
    commit_and_check(2);

    // Out-of-range index in LOAD
    drive_byte(0, 8'h01, 1'b0, 1'b0);
    drive_byte(NB, 8'h02, 1'b0, 1'b0);
    check_eq("range_err", bus.err_incomplete, 1);
    check_eq("range_state", bus.state_out, 0);

    // Reset mid-LOAD
    send_bytes(3, 0, 30);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_bank  = '0;
    exp_count = 8'd0;
    check_eq("midrst_state", bus.state_out, 0);
    check_eq("midrst_params", bus.params_out, exp_bank);
    check_eq("midrst_count", bus.commit_count, exp_count);
    send_bytes(3, 31, NB-1);
    strobe(1'b1, 1'b0, 1'b0);
    check_eq("midrst_no_err", bus.err_incomplete, 0);
    check_eq("midrst_stays_idle", bus.state_out, 0);

    // Timeout boundary: one cycle short stays in LOAD, full count discards
    drive_byte(0, 8'h77, 1'b0, 1'b0);
    repeat (TO-1) step();
    check_eq("timeout_not_yet", bus.state_out, 1);
    check_eq("timeout_no_err_yet", bus.err_incomplete, 0);
    step();
    check_eq("timeout_err", bus.err_incomplete, 1);
    check_eq("timeout_state", bus.state_out, 0);
    send_bytes(3, 0, NB-1);
    strobe(1'b1, 1'b0, 1'b0);
    check_eq("post_timeout_armed", bus.state_out, 2);
    commit_and_check(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/param_commit_ctrl.md
PARAM_COMMIT_CTRL -- requirements
Module: param_commit_ctrl

Interface
REQ-001 Parameter NBYTES, default 60: bytes per scene packet.
REQ-002 Parameter TIMEOUT_CYC, default 20000: max clk_40 cycles allowed between bytes in LOAD.
REQ-003 clk_40  input  1  clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 byte_valid  input  1  one-cycle strobe; a UART byte is present.
REQ-006 byte_idx  input  7  byte index within packet.
REQ-007 byte_data  input  8  byte value.
REQ-008 pkt_done  input  1  one-cycle strobe; receiver reports end of packet.
REQ-009 frame_start  input  1  one-cycle strobe at the first pixel of a frame.
REQ-010 vs_busy  input  1  vertex stage is mid-setup; commit forbidden.
REQ-011 params_out  output  8*NBYTES  active bank; byte k is on bits [8k+7:8k].
REQ-012 commit_pulse  output  1  one-cycle strobe; new params_out valid (drives vertex-stage start).
REQ-013 err_incomplete  output  1  one-cycle strobe; packet discarded.
REQ-014 overrun  output  1  one-cycle strobe; byte dropped while a packet is pending.
REQ-015 commit_count  output  8  number of commits, wraps 255->0.
REQ-016 state_out  output  3  current FSM state encoding.

Function
REQ-017 The block SHALL hold a shadow bank (NBYTES x 8) and a received mask (NBYTES bits), separate from the active bank.
REQ-018 FSM states SHALL be IDLE=0, LOAD=1, ARMED=2, COMMIT=3.
REQ-019 IDLE: byte_valid with byte_idx==0 -> write shadow[0], set mask to only bit 0, go LOAD; byte_valid with any other index is ignored with no flag.
REQ-020 LOAD: byte_valid with byte_idx<NBYTES -> write shadow[byte_idx] and set its mask bit; a repeat index overwrites.
REQ-021 LOAD: byte_idx>=NBYTES -> byte ignored, err_incomplete pulses, go IDLE.
REQ-022 LOAD: pkt_done with the mask all ones -> go ARMED; pkt_done with any mask bit clear -> err_incomplete pulses, go IDLE.
REQ-023 byte_valid and pkt_done in the same LOAD cycle: the byte SHALL be written and counted in the completeness check.
REQ-024 LOAD: idle counter clears on every byte_valid; when it reaches TIMEOUT_CYC -> err_incomplete pulses, go IDLE.
REQ-025 ARMED: frame_start with vs_busy==0 -> go COMMIT; frame_start with vs_busy==1 -> stay ARMED and wait for the next frame_start.
REQ-026 ARMED or COMMIT: every byte_valid SHALL be dropped with an overrun pulse; shadow is unchanged.
REQ-027 ARMED: pkt_done SHALL be ignored.
REQ-028 COMMIT lasts one cycle: params_out <= shadow, commit_count increments, go IDLE.
REQ-029 commit_pulse SHALL assert in the cycle after the COMMIT cycle, when params_out already holds the new bank.
REQ-030 frame_start in the same cycle as the LOAD->ARMED transition SHALL NOT commit; commit waits for the next frame_start.
REQ-031 params_out SHALL change only via COMMIT; a discarded packet never alters params_out.
REQ-032 All strobe outputs SHALL be registered, single-cycle pulses.

Reset
REQ-033 reset SHALL force state IDLE and clear all of: params_out, shadow, mask, idle counter, commit_count, commit_pulse, err_incomplete and overrun; this applies in any state.
REQ-034 After reset deasserts, the first accepted byte SHALL be byte_idx 0 in IDLE.

Verification
REQ-035 Full packet: bytes 0..59 with data=idx+1, then pkt_done, then frame_start -> one commit_pulse; params_out byte k = k+1; commit_count=1.
REQ-036 Incomplete packet: bytes 0..58, then pkt_done -> err_incomplete pulses and state IDLE; after frame_start, params_out is still 0 and there is no commit_pulse.
REQ-037 Busy gate: packet complete, frame_start with vs_busy=1 -> no commit; next frame_start with vs_busy=0 -> commit_pulse one cycle after COMMIT.
REQ-038 Overrun: packet armed, then byte_valid idx0 data=0xAA -> overrun pulses; committed byte 0 keeps its old value.
REQ-039 Timeout: byte 0 only, then 20000 idle cycles -> err_incomplete pulses, state IDLE; a fresh full packet then commits correctly.
REQ-040 Reset mid-LOAD: after byte 30, assert reset for 1 cycle -> state 0, params_out 0, commit_count 0; bytes 31..59 and pkt_done are then ignored with no error.
